// File: rtl/inst_mem_ctrl_pkg.sv
// Shared constants and types for the instruction-memory backing controller.
package inst_mem_ctrl_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MEM_LATENCY_DEF = 4;
    localparam logic [DATA_W-1:0] MEM_INIT_VAL = 32'h0000_0013;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_BUSY  = 2'd1,
        MEM_RESP  = 2'd2,
        MEM_DRAIN = 2'd3
    } mem_state_e;

    // Request payload captured at acceptance and replayed in RESP
    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } mem_lat_t;

endpackage

// File: rtl/inst_mem_array.sv
// Synchronous-write, combinational-read word RAM; contents start at INIT_VAL
// and are never cleared by reset.
module inst_mem_array
    import inst_mem_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [DATA_W-1:0] INIT_VAL = MEM_INIT_VAL
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_ctrl.sv
// Fixed-latency main-memory controller behind the instruction cache.
// Optional build macro INST_MEM_STAT_EN adds rd_cnt/wr_cnt access counters.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       LATENCY  = MEM_LATENCY_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = MEM_INIT_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_req_addr,
    input  logic              mem_req_valid,
    input  logic              mem_req_wr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_req_data,
    output logic              mem_req_ready,
`ifdef INST_MEM_STAT_EN
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
`endif
    output logic              busy
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] idx_q, req_idx_c, rd_idx_c;
    mem_lat_t          lat_q, cur_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              accept_c, resp_c, we_c;
    logic              ready_d, busy_d;
    logic [DATA_W-1:0] data_d;
    logic              unused_addr_bits;

    assign req_idx_c        = mem_req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_req_addr[31:ADDR_W+2], mem_req_addr[1:0]};
    assign accept_c         = (state_q == MEM_IDLE) && mem_req_valid;
    assign resp_c           = (state_q == MEM_RESP);
    // A reset landing in RESP drops the write
    assign we_c             = resp_c && lat_q.wr && !rst;
    // In IDLE the live request feeds the read port so LATENCY==1 can respond next cycle
    assign rd_idx_c         = (state_q == MEM_IDLE) ? req_idx_c : idx_q;
    assign cur_c            = (state_q == MEM_IDLE) ? mem_lat_t'{wr: mem_req_wr, wdata: mem_wr_data} : lat_q;

    inst_mem_array #(
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk   (clk),
        .we    (we_c),
        .waddr (idx_q),
        .wdata (lat_q.wdata),
        .raddr (rd_idx_c),
        .rdata (rd_data_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE:  if (mem_req_valid) state_d = (LATENCY == 1) ? MEM_RESP : MEM_BUSY;
            MEM_BUSY:  if (cnt_q == CNT_W'(1)) state_d = MEM_RESP;
            MEM_RESP:  state_d = MEM_DRAIN;
            MEM_DRAIN: if (!mem_req_valid) state_d = MEM_IDLE;
            default:   state_d = MEM_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, aligned with entry into RESP
    always_comb begin
        ready_d = 1'b0;
        data_d  = mem_req_data;
        busy_d  = (state_d != MEM_IDLE);
        if (state_d == MEM_RESP) begin
            ready_d = 1'b1;
            data_d  = cur_c.wr ? cur_c.wdata : rd_data_c;
        end
    end

    // Request latch, latency counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            lat_q         <= '0;
            mem_req_ready <= 1'b0;
            mem_req_data  <= '0;
            busy          <= 1'b0;
        end else begin
            if (accept_c) begin
                cnt_q <= CNT_W'(LATENCY - 1);
                idx_q <= req_idx_c;
                lat_q <= cur_c;
            end else if (state_q == MEM_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            mem_req_ready <= ready_d;
            mem_req_data  <= data_d;
            busy          <= busy_d;
        end
    end

`ifdef INST_MEM_STAT_EN
    // Completed-access counters, wrapping modulo 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (resp_c) begin
            if (lat_q.wr) begin
                wr_cnt <= wr_cnt + 32'd1;
            end else begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: expected responses are queued at
// request issue and compared when the ready pulse arrives.
`timescale 1ns/1ps
module tb_inst_mem_ctrl;

    localparam int unsigned LAT = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic        busy;
`ifdef INST_MEM_STAT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    int checks = 0;
    int passed = 0;
    int rd_done = 0;
    int wr_done = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [int];

    inst_mem_ctrl #(.ADDR_W(10), .LATENCY(LAT), .INIT_VAL(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_addr  (mem_req_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_wr_data   (mem_wr_data),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
`ifdef INST_MEM_STAT_EN
        .rd_cnt        (rd_cnt),
        .wr_cnt        (wr_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int widx(input logic [31:0] a);
        logic [9:0] w;
        w = a[11:2];
        return int'(w);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(widx(a))) return model_mem[widx(a)];
        return NOP;
    endfunction

    // One request: idle gap, issue, wait for ready, score, hold valid for 'hold' extra cycles
    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int hold, input string name);
        int lat;
        logic [31:0] e;
        mem_req_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_addr  = addr;
        mem_req_wr    = wr;
        mem_wr_data   = wd;
        mem_req_valid = 1'b1;
        exp_q.push_back(wr ? wd : model_rd(addr));
        if (wr) model_mem[widx(addr)] = wd;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (mem_req_ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (lat != int'(LAT)) $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, LAT);
        else passed++;
        if (lat != 0) begin
            if (wr) wr_done++; else rd_done++;
            checks++;
            if (mem_req_data !== e) $display("FAIL %s data: got %h expected %h", name, mem_req_data, e);
            else passed++;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (mem_req_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL %s drain_hold%0d: ready=%b busy=%b expected ready=0 busy=1",
                         name, h, mem_req_ready, busy);
            else passed++;
        end
        mem_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b0) $display("FAIL %s ready_after: got %b expected 0", name, mem_req_ready);
        else passed++;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mem_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b0 || mem_req_data !== 32'h0 || busy !== 1'b0)
            $display("FAIL reset_outputs: ready=%b data=%h busy=%b expected 0/00000000/0",
                     mem_req_ready, mem_req_data, busy);
        else passed++;
        rd_done = 0;
        wr_done = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_wr = 1'b0;
        mem_req_addr = '0;
        mem_wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b0 || mem_req_data !== 32'h0 || busy !== 1'b0)
            $display("FAIL initial_reset: ready=%b data=%h busy=%b expected 0/00000000/0",
                     mem_req_ready, mem_req_data, busy);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_latency();
        do_req(32'h0000_0040, 1'b0, '0, 0, "read_init");
    endtask

    task automatic test_write_then_read();
        do_req(32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 0, "write_beef");
        do_req(32'h0000_0104, 1'b0, '0, 0, "read_beef");
        do_req(32'h0000_0108, 1'b0, '0, 0, "read_neighbour");
    endtask

    task automatic test_drain_hold();
        do_req(32'h0000_0200, 1'b1, 32'h1234_5678, 3, "write_hold");
        do_req(32'h0000_0200, 1'b0, '0, 0, "read_after_hold");
    endtask

    task automatic test_aliasing();
        do_req(32'h0000_1004, 1'b1, 32'h0000_0001, 0, "alias_write");
        do_req(32'h0000_0004, 1'b0, '0, 0, "alias_read");
    endtask

    task automatic test_reset_abort();
        mem_req_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_addr  = 32'h0000_0008;
        mem_req_wr    = 1'b1;
        mem_wr_data   = 32'hCAFE_F00D;
        mem_req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy);
        else passed++;
        apply_reset();
        do_req(32'h0000_0008, 1'b0, '0, 0, "read_after_abort");
    endtask

`ifdef INST_MEM_STAT_EN
    task automatic test_stats();
        apply_reset();
        do_req(32'h0000_0010, 1'b0, '0, 0, "st_r0");
        do_req(32'h0000_0014, 1'b1, 32'hA5A5_0001, 0, "st_w0");
        do_req(32'h0000_0014, 1'b0, '0, 0, "st_r1");
        do_req(32'h0000_0018, 1'b1, 32'hA5A5_0002, 1, "st_w1");
        do_req(32'h0000_0018, 1'b0, '0, 0, "st_r2");
        checks++;
        if (rd_cnt !== 32'(rd_done) || wr_cnt !== 32'(wr_done) || rd_done != 3 || wr_done != 2)
            $display("FAIL stat_counts: rd_cnt=%0d wr_cnt=%0d expected 3/2", rd_cnt, wr_cnt);
        else passed++;
        apply_reset();
        checks++;
        if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0)
            $display("FAIL stat_reset: rd_cnt=%0d wr_cnt=%0d expected 0/0", rd_cnt, wr_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_drain_hold();
        test_aliasing();
        test_reset_abort();
`ifdef INST_MEM_STAT_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
- Backing main-memory controller sitting directly downstream of the instruction cache.
- Serves single-word read (line fill) and write (write-back) requests issued over the cache's mem_req_* valid/ready interface.
- Models a fixed-latency memory array with a request/response FSM, so cache miss handling can be exercised cycle-accurately.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words; word index = mem_req_addr[ADDR_W+1:2].
- LATENCY, 4, cycles from request acceptance to the ready pulse; legal range 1..15.
- INIT_VAL, 32'h0000_0013, reset/initial content of every word (RISC-V NOP).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_req_addr  in  32  byte address; bits [1:0] and bits above ADDR_W+1 ignored (aliasing)
- mem_req_valid  in  1  request valid; held high by the cache until ready
- mem_req_wr  in  1  1 = write, 0 = read
- mem_wr_data  in  32  write data
- mem_req_data  out  32  read data; valid only while mem_req_ready=1
- mem_req_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

Reset:
- rst is synchronous and active-high; clk is the clock.
- Reset values: mem_req_ready=0, mem_req_data=0, busy=0, state=IDLE, counter=0.
- Array contents are NOT cleared by rst; they are initialised to INIT_VAL at time zero only.

Behaviour:
- FSM states: IDLE, BUSY, RESP, DRAIN.
- IDLE: if mem_req_valid=1, accept the request. Latch addr word index, wr and wr_data into internal registers; load counter=LATENCY-1; go to BUSY. If LATENCY==1, go directly to RESP.
- BUSY: decrement the counter each cycle; at counter==1 go to RESP. Input changes during BUSY are ignored; only latched values are used.
- RESP, one cycle: mem_req_ready=1.
  - Read: mem_req_data = array[latched index].
  - Write: array[latched index] <= latched data at the end of this cycle; mem_req_data = latched write data (echo).
  - Next state is always DRAIN.
- DRAIN: wait until mem_req_valid=0, then go to IDLE. No request is accepted in DRAIN. This prevents double-servicing a request whose valid drops one cycle after ready.
- Latency: acceptance at cycle T gives ready high in cycle T+LATENCY exactly.
- Read-after-write to the same word returns the new data for any request accepted after the write's RESP cycle.
- Outside RESP: mem_req_ready=0 and mem_req_data holds its last driven value.
- rst in any state (including BUSY/RESP) aborts the transaction. A pending write is discarded if rst arrives before its RESP cycle; rst in the RESP cycle takes priority and the write is dropped.
- If mem_req_valid falls during BUSY, the access still completes; ready pulses; DRAIN exits immediately on the next cycle.
- Counter width: 4 bits.

Optional Feature:
- Macro: INST_MEM_STAT_EN.
- Defined:
  - Adds outputs rd_cnt[31:0] and wr_cnt[31:0], reset to 0.
  - rd_cnt increments in each read RESP cycle; wr_cnt increments in each write RESP cycle.
  - Both wrap modulo 2**32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (alongside the cache stage constants): FSM state encodings MEM_IDLE=2'd0, MEM_BUSY=2'd1, MEM_RESP=2'd2, MEM_DRAIN=2'd3; default LATENCY; INIT_VAL.
- One natural sub-module: inst_mem_array. Synchronous-write, combinational-read 32-bit RAM with depth 2**ADDR_W and a time-zero init loop. The controller FSM is the top level.

Test Plan:
- Reset, then read addr 32'h0000_0040 with LATENCY=4 -> ready high exactly 4 cycles after acceptance; data=32'h0000_0013; ready low the following cycle.
- Write 32'hDEAD_BEEF to 32'h0000_0104; drop valid for 1 cycle; read 32'h0000_0104 -> read returns 32'hDEAD_BEEF; exactly one array update.
- Hold mem_req_valid high for 3 cycles after ready -> FSM stays in DRAIN; no second ready pulse; first new acceptance occurs one cycle after valid falls and rises again.
- Aliasing: write 32'h1 to 32'h0000_1004, read 32'h0000_0004 (ADDR_W=10) -> returns 32'h1.
- Assert rst during BUSY of a write of 32'hCAFE_F00D to 32'h0000_0008, then read 32'h0000_0008 -> returns 32'h0000_0013; outputs zero during reset.
- With INST_MEM_STAT_EN: 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2; after rst both are 0.
